inst_fetch_resp: RTL and testbench

- Responder side of the PC/fetch interface: consumes pc and ce from the PC generator, reads the instruction word from instruction memory over a req/ack handshake, presents it downstream with valid/ready, then issues a one-cycle pc_en step pulse to advance (or branch) the PC.
- Sits between the PC register, the instruction memory and the decode stage; owns all fetch sequencing, flush and fault detection.

---
 rtl/inst_fetch_resp.sv | 215 +++++++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: responder side of the PC/fetch interface.
// Takes the current pc from the PC generator and reads the instruction word
// over a req/ack handshake. It hands the word to decode with valid/ready and
// then pulses pc_en for one cycle so the PC register advances or branches.
// A flush discards the fetch in flight. A misaligned pc or a missing ack
// latches a sticky fault that only reset clears.
module inst_fetch_resp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              flush,
    output logic              pc_en,
    output logic              fetch_err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_STEP  = 3'd3,
        S_STEP2 = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Instruction words must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic                pc_en_q, pc_en_d;
    logic                fetch_err_q, fetch_err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Next-state and next-output logic of the fetch sequencer.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_en_d      = 1'b0;
        fetch_err_d  = fetch_err_q;
        err_code_d   = err_code_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ce) begin
                    if (!is_word_aligned(pc[1:0])) begin
                        fetch_err_d = 1'b1;
                        err_code_d  = ERR_ALIGN;
                        state_d     = S_ERR;
                    end else begin
                        mem_addr_d = pc;
                        mem_req_d  = 1'b1;
                        cnt_d      = CNT_ZERO;
                        state_d    = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cnt_d     = CNT_ZERO;
                    if (drop_q || flush) begin
                        // The read belongs to a path that was flushed: drop it.
                        drop_d  = 1'b0;
                        pc_en_d = 1'b1;
                        state_d = S_STEP;
                    end else begin
                        inst_d       = mem_rdata;
                        inst_pc_d    = mem_addr_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_ERR;
                end else begin
                    // The read stays outstanding. A flush only marks it for discard.
                    cnt_d = cnt_q + CNT_ONE;
                    if (flush) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end

            S_HOLD: begin
                if (flush || inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_en_d      = 1'b1;
                    state_d      = S_STEP;
                end else begin
                    inst_valid_d = 1'b1;
                end
            end

            S_STEP: begin
                // pc_en is high this cycle. Force it low next cycle so the next pulse starts on a fresh edge.
                state_d = S_STEP2;
            end

            S_STEP2: begin
                if (!ce) begin
                    state_d = S_IDLE;
                end else if (!is_word_aligned(pc[1:0])) begin
                    fetch_err_d = 1'b1;
                    err_code_d  = ERR_ALIGN;
                    state_d     = S_ERR;
                end else begin
                    mem_addr_d = pc;
                    mem_req_d  = 1'b1;
                    cnt_d      = CNT_ZERO;
                    state_d    = S_REQ;
                end
            end

            S_ERR: begin
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
                fetch_err_d  = 1'b1;
                state_d      = S_ERR;
            end

            default: begin
                // Unreachable encoding: return to a quiet idle.
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
                drop_d       = 1'b0;
                cnt_d        = CNT_ZERO;
                err_code_d   = ERR_NONE;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            pc_en_q      <= 1'b0;
            fetch_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            drop_q       <= 1'b0;
            cnt_q        <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            pc_en_q      <= pc_en_d;
            fetch_err_q  <= fetch_err_d;
            err_code_q   <= err_code_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign pc_en      = pc_en_q;
    assign fetch_err  = fetch_err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp. The behavioural model predicts each output from
// the fetch rules. A small PC register and memory responder make up the
// environment. Directed scenarios come first, then randomized episodes.
module tb_inst_fetch_resp;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          ce         = 1'b0;
    logic [AW-1:0] pc         = '0;
    logic          mem_ack    = 1'b0;
    logic [DW-1:0] mem_rdata  = '0;
    logic          inst_ready = 1'b0;
    logic          flush      = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          pc_en;
    logic          fetch_err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    inst_fetch_resp #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .flush(flush), .pc_en(pc_en), .fetch_err(fetch_err), .err_code(err_code)
    );

    int errors = 0;
    int checks = 0;

    // Environment: PC register and memory responder.
    bit            auto_pc    = 1'b1;
    bit            br_pend    = 1'b0;
    logic [AW-1:0] br_tgt     = '0;
    bit            mem_pend   = 1'b0;
    int            mem_lat    = 0;
    int            lat_sel    = 0;
    bit            lat_rand   = 1'b0;
    bit            data_fixed = 1'b0;
    logic [DW-1:0] data_val   = '0;

    // Behavioural model: the expected value of every output.
    logic          m_req, m_valid, m_pcen, m_err, m_drop;
    logic [1:0]    m_code;
    logic [AW-1:0] m_addr, m_ipc;
    logic [DW-1:0] m_inst;
    int            m_wait;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_valid = 1'b0; m_pcen = 1'b0; m_err = 1'b0; m_drop = 1'b0;
        m_code = 2'b00; m_addr = '0; m_ipc = '0; m_inst = '0; m_wait = 0;
    endtask

    // Advance the model by one clock edge, using the inputs the edge will sample.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (m_err) begin
            m_req = 1'b0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_req  = 1'b0;
                m_wait = 0;
                if (m_drop || flush) begin
                    m_drop = 1'b0;
                    m_pcen = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_inst  = mem_rdata;
                    m_ipc   = m_addr;
                end
            end else if (m_wait + 1 == TO) begin
                m_req = 1'b0; m_err = 1'b1; m_code = 2'b10;
            end else begin
                m_wait++;
                if (flush) m_drop = 1'b1;
            end
        end else if (m_valid) begin
            if (inst_ready || flush) begin
                m_valid = 1'b0; m_pcen = 1'b1;
            end
        end else if (m_pcen) begin
            m_pcen = 1'b0;
        end else if (ce) begin
            // A quiet cycle with ce high is a fetch point.
            if (pc[1:0] != 2'b00) begin
                m_err = 1'b1; m_code = 2'b01;
            end else begin
                m_req = 1'b1; m_addr = pc; m_wait = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("inst_valid", inst_valid, m_valid);
        chk("pc_en", pc_en, m_pcen);
        chk("fetch_err", fetch_err, m_err);
        chk("err_code", err_code, m_code);
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 39);
        if (r < 34) return r % 4;
        else if (r < 36) return TO - 1;
        else if (r < 38) return TO;
        else return TO + 5;
    endfunction

    // One clock: update the model, cross the edge, then update the environment and compare.
    task automatic tick();
        logic pcen_pre;
        model_edge();
        pcen_pre = pc_en;
        @(posedge clk);
        #1;
        if (auto_pc && pcen_pre && rst) begin
            pc = br_pend ? br_tgt : pc + AW'(4);
            br_pend = 1'b0;
        end
        mem_ack = 1'b0;
        if (!mem_pend && mem_req) begin
            mem_pend = 1'b1;
            mem_lat  = lat_rand ? pick_lat() : lat_sel;
        end
        if (mem_pend) begin
            if (mem_lat == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = data_fixed ? data_val : DW'($urandom);
                mem_pend  = 1'b0;
            end else begin
                mem_lat--;
            end
        end
        compare_all();
    endtask

    initial begin
        bit found;
        int req_cycles;
        model_reset();

        // Reset state.
        rst = 1'b0; ce = 1'b0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        rst = 1'b1;

        // First fetch at pc 0 with zero-wait memory.
        data_fixed = 1'b1; data_val = 32'h2001_0005; lat_sel = 0;
        pc = 32'h0; ce = 1'b1; inst_ready = 1'b1;
        tick();
        chk("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 32'h0);
        tick();
        chk("t1_inst", inst, 32'h2001_0005);
        chk("t1_inst_pc", inst_pc, 32'h0);
        chk("t1_valid", inst_valid, 1'b1);
        tick();
        chk("t1_pc_en", pc_en, 1'b1);
        inst_ready = 1'b0;
        data_val = 32'h0bad_f00d;
        tick();
        chk("t1_pc_en_low", pc_en, 1'b0);
        tick();
        chk("t1_next_addr", mem_addr, 32'h4);
        chk("t1_next_req", mem_req, 1'b1);

        // Decode stalls for 5 cycles; a stray ack must not disturb the held word.
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
            tick();
            chk("t2_valid", inst_valid, 1'b1);
            chk("t2_inst", inst, 32'h0bad_f00d);
            chk("t2_pc_en", pc_en, 1'b0);
        end
        inst_ready = 1'b1;
        tick();
        chk("t2_pulse", pc_en, 1'b1);

        // Flush two cycles into a slow read.
        lat_sel = 5;
        tick();
        tick();
        chk("t3_addr", mem_addr, 32'h8);
        tick();
        flush = 1'b1; br_pend = 1'b1; br_tgt = 32'h100;
        tick();
        flush = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pc_en) found = 1'b1;
            else chk("t3_no_valid", inst_valid, 1'b0);
        end
        chk("t3_pc_en_seen", found, 1'b1);
        lat_sel = 0;
        tick();
        chk("t3_pulse_len", pc_en, 1'b0);
        tick();
        chk("t3_branch_addr", mem_addr, 32'h100);
        chk("t3_branch_req", mem_req, 1'b1);

        // The next PC is misaligned.
        br_pend = 1'b1; br_tgt = 32'h6;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (fetch_err) found = 1'b1;
        end
        chk("t4_err", found, 1'b1);
        chk("t4_code", err_code, 2'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_req", mem_req, 1'b0);
            chk("t4_no_pc_en", pc_en, 1'b0);
            chk("t4_sticky", fetch_err, 1'b1);
        end

        // Ack timeout, then a late ack.
        rst = 1'b0; mem_pend = 1'b0; br_pend = 1'b0;
        tick();
        rst = 1'b1; pc = 32'h40; lat_sel = TO + 3;
        tick();
        chk("t5_req", mem_req, 1'b1);
        req_cycles = 1;
        for (int i = 0; i < 3 * TO; i++) begin
            tick();
            if (mem_req) req_cycles++;
            else break;
        end
        chk("t5_req_cycles", req_cycles, TO);
        chk("t5_err", fetch_err, 1'b1);
        chk("t5_code", err_code, 2'b10);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_late_ack", {fetch_err, err_code, inst_valid, mem_req}, 5'b11000);
        end

        // Asynchronous reset while a word is held.
        rst = 1'b0; mem_pend = 1'b0;
        tick();
        rst = 1'b1; pc = 32'h200; lat_sel = 0; inst_ready = 1'b0; data_fixed = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (inst_valid) found = 1'b1;
        end
        chk("t6_hold", found, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", inst_valid, 1'b0);
        chk("t6_async_inst", inst, 32'h0);
        chk("t6_async_pc", inst_pc, 32'h0);
        chk("t6_async_addr", mem_addr, 32'h0);
        model_reset();
        ce = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle", mem_req, 1'b0);
        end
        ce = 1'b1;
        tick();
        chk("t6_resume", mem_addr, 32'h200);

        // Randomized episodes.
        lat_rand = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            rst = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_pend = 1'b0; br_pend = 1'b0;
            pc = AW'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 15) == 0) pc = pc | AW'(2);
            tick();
            rst = 1'b1;
            for (int c = 0; c < 150; c++) begin
                ce         = ($urandom_range(0, 7) != 0);
                inst_ready = ($urandom_range(0, 2) != 0);
                flush      = ($urandom_range(0, 9) == 0);
                if (flush) begin
                    br_pend = 1'b1;
                    br_tgt  = AW'($urandom_range(0, 4095)) << 2;
                    if ($urandom_range(0, 15) == 0) br_tgt = br_tgt | AW'(1);
                end
                if (!mem_ack && $urandom_range(0, 59) == 0) begin
                    mem_ack = 1'b1; mem_rdata = DW'($urandom);
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
